// File: rtl/qsys_relay_pipe.sv
// Chain of DEPTH skid-buffered relay stages; each stage registers its ready/valid so
// no input reaches an output combinationally. Capacity is two words per stage.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | stage holds no word
// ST_MAIN  | main register holds the word on offer
// ST_FULL  | main on offer, skid holds the next word
module qsys_relay_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 2
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic [DATA_WIDTH-1:0]          i_data,
    input  logic                           i_valid,
    output logic                           o_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [$clog2(2*DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(2*DEPTH+1);

    generate
        if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
            $fatal(1, "qsys_relay_pipe: DEPTH must be 1..16");
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
            $fatal(1, "qsys_relay_pipe: DATA_WIDTH must be 1..1024");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_MAIN  = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    stage_state_e            state_q [DEPTH];
    stage_state_e            state_d [DEPTH];
    logic [DATA_WIDTH-1:0]   main_q  [DEPTH];
    logic [DATA_WIDTH-1:0]   main_d  [DEPTH];
    logic [DATA_WIDTH-1:0]   skid_q  [DEPTH];
    logic [DATA_WIDTH-1:0]   skid_d  [DEPTH];

    logic [DEPTH-1:0]        stg_out_valid;
    logic [DEPTH-1:0]        stg_in_ready;
    logic [DEPTH-1:0]        stg_in_valid;
    logic [DEPTH-1:0]        stg_out_ready;
    logic [DATA_WIDTH-1:0]   stg_in_data [DEPTH];
    logic [CW-1:0]           occ_sum;

    // Handshake outputs of every stage depend on its state alone.
    always_comb begin
        stg_out_valid = '0;
        stg_in_ready  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            stg_out_valid[k] = (state_q[k] != ST_EMPTY);
            stg_in_ready[k]  = (state_q[k] != ST_FULL);
        end
    end

    always_comb begin
        stg_in_valid    = '0;
        stg_out_ready   = '0;
        stg_in_valid[0] = i_valid;
        stg_in_data[0]  = i_data;
        for (int k = 1; k < DEPTH; k++) begin
            stg_in_valid[k] = stg_out_valid[k-1];
            stg_in_data[k]  = main_q[k-1];
        end
        stg_out_ready[DEPTH-1] = i_ready;
        for (int k = 0; k < DEPTH-1; k++) begin
            stg_out_ready[k] = stg_in_ready[k+1];
        end
    end

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            state_d[k] = state_q[k];
            main_d[k]  = main_q[k];
            skid_d[k]  = skid_q[k];
            case (state_q[k])
                ST_EMPTY: begin
                    if (stg_in_valid[k]) begin
                        state_d[k] = ST_MAIN;
                        main_d[k]  = stg_in_data[k];
                    end
                end
                ST_MAIN: begin
                    if (stg_in_valid[k] && stg_out_ready[k]) begin
                        main_d[k] = stg_in_data[k];
                    end else if (stg_in_valid[k]) begin
                        state_d[k] = ST_FULL;
                        skid_d[k]  = stg_in_data[k];
                    end else if (stg_out_ready[k]) begin
                        state_d[k] = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (stg_out_ready[k]) begin
                        state_d[k] = ST_MAIN;
                        main_d[k]  = skid_q[k];
                    end
                end
                default: state_d[k] = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 0; k < DEPTH; k++) begin
                state_q[k] <= ST_EMPTY;
                main_q[k]  <= '0;
                skid_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                state_q[k] <= state_d[k];
                main_q[k]  <= main_d[k];
                skid_q[k]  <= skid_d[k];
            end
        end
    end

    // Occupancy is decoded from state, so a simultaneous accept and emit leaves it unchanged.
    always_comb begin
        occ_sum = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (state_q[k] == ST_MAIN) begin
                occ_sum = occ_sum + CW'(1);
            end else if (state_q[k] == ST_FULL) begin
                occ_sum = occ_sum + CW'(2);
            end
        end
    end

    assign o_ready = stg_in_ready[0];
    assign o_valid = stg_out_valid[DEPTH-1];
    assign o_data  = main_q[DEPTH-1];
    assign o_count = occ_sum;

endmodule

// File: tb/tb_qsys_relay_pipe.sv
// Bench for qsys_relay_pipe (DATA_WIDTH=8, DEPTH=3): directed latency/backpressure cases
// plus a random run, all outputs checked by a queue-based scoreboard.
module tb_qsys_relay_pipe;

    localparam int DW    = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(2*DEPTH+1);

    logic          clock = 1'b0;
    logic          resetn;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_count;

    int n_total  = 0;
    int n_passed = 0;

    logic [DW-1:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    qsys_relay_pipe #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .resetn  (resetn),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_count (o_count)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_passed++;
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_empty(input string name);
        for (int c = 0; c < 40; c++) begin
            if (o_count == 0 && !o_valid) break;
            tick();
        end
        chk(name, {31'd0, o_valid}, 32'd0);
        chk({name, "_count"}, 32'(o_count), 32'd0);
    endtask

    always @(negedge resetn) begin
        exp_q.delete();
        hold_prev = 1'b0;
    end

    // Transfers are decided here for the coming rising edge; nothing changes between
    // this falling edge and that rising edge.
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            chk("count_vs_model", 32'(o_count), 32'(exp_q.size()));
            if (hold_prev) begin
                chk("hold_valid", {31'd0, o_valid}, 32'd1);
                chk("hold_data", 32'(o_data), 32'(prev_data));
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_out: got %0h expected no word at %0t", o_data, $time);
                end else begin
                    chk("out_data", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
            if (i_valid && o_ready) exp_q.push_back(i_data);
            hold_prev = o_valid && !i_ready;
            prev_data = o_data;
        end
    end

    initial begin
        int acc;
        logic will;

        resetn  = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_data  = '0;
        tick();
        tick();
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_data",  32'(o_data), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);

        // Single word: accepted on the first edge after release, out after 3 edges.
        resetn  = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'hA5;
        i_ready = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            i_valid = 1'b0;
            chk("single_count", 32'(o_count), (e < 4) ? 32'd1 : 32'd0);
            chk("single_valid", {31'd0, o_valid}, (e == 3) ? 32'd1 : 32'd0);
            if (e == 3) chk("single_data", 32'(o_data), 32'hA5);
        end

        // Streaming with downstream always ready.
        for (int n = 0; n < 32; n++) begin
            i_valid = 1'b1;
            i_data  = 8'(n);
            tick();
            chk("stream_ready", {31'd0, o_ready}, 32'd1);
            if (n >= 2) begin
                chk("stream_valid", {31'd0, o_valid}, 32'd1);
                chk("stream_data", 32'(o_data), 32'(n - 2));
            end
        end
        i_valid = 1'b0;
        wait_empty("stream_drain");

        // Backpressure: fill to capacity.
        i_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 12; c++) begin
            i_valid = 1'b1;
            i_data  = 8'(8'h10 + acc);
            will = o_ready;
            tick();
            if (will) acc++;
        end
        i_valid = 1'b0;
        chk("full_accepted", 32'(acc), 32'd6);
        chk("full_ready", {31'd0, o_ready}, 32'd0);
        chk("full_count", 32'(o_count), 32'd6);
        chk("full_data", 32'(o_data), 32'h10);
        chk("full_valid", {31'd0, o_valid}, 32'd1);

        // Release: words leave back to back; the free slot walks back one stage per edge.
        i_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chk("release_valid", {31'd0, o_valid}, 32'd1);
            chk("release_data", 32'(o_data), 32'(8'h10 + k));
            tick();
            chk("release_ready", {31'd0, o_ready}, (k + 1 >= DEPTH) ? 32'd1 : 32'd0);
        end
        wait_empty("release_drain");

        // Random traffic; the falling-edge monitor checks data order and occupancy.
        for (int c = 0; c < 10000; c++) begin
            i_valid = 1'($urandom_range(0, 1));
            i_ready = 1'($urandom_range(0, 1));
            i_data  = 8'($urandom_range(0, 255));
            tick();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_empty("random_drain");

        // Asynchronous reset with four words held and traffic flowing.
        i_ready = 1'b0;
        i_valid = 1'b1;
        for (int n = 0; n < 20 && o_count != 4; n++) begin
            i_data = 8'(8'h40 + n);
            tick();
        end
        chk("pre_reset_count", 32'(o_count), 32'd4);
        i_ready = 1'b1;
        i_data  = 8'h4F;
        tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_valid", {31'd0, o_valid}, 32'd0);
        chk("async_count", 32'(o_count), 32'd0);
        chk("async_ready", {31'd0, o_ready}, 32'd1);
        chk("async_data",  32'(o_data), 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        for (int n = 0; n < 16; n++) begin
            i_valid = 1'b1;
            i_data  = 8'(8'h80 + n);
            tick();
        end
        i_valid = 1'b0;
        wait_empty("post_reset_drain");
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
